// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared timer width, phase durations and implicit-state helper
// Contents:
//   TIMER_W                    default counter width
//   GREEN_T/YELLOW_T/RED_T     phase durations the controller drives onto load_val
//   timer_state()              classifies the implicit IDLE/RUN/PAUSE state from q and en
package down_timer_pkg;

    localparam int TIMER_W = 16;

    localparam logic [TIMER_W-1:0] GREEN_T  = 16'd30;
    localparam logic [TIMER_W-1:0] YELLOW_T = 16'd5;
    localparam logic [TIMER_W-1:0] RED_T    = 16'd25;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_PAUSE
    } timer_state_e;

    // The timer has no state register; its mode is fully implied by q and en.
    function automatic timer_state_e timer_state(input logic [TIMER_W-1:0] q, input logic en);
        return (q == '0) ? T_IDLE : (en ? T_RUN : T_PAUSE);
    endfunction

endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: controller <-> phase timer bundle
// Signals:
//   load, load_val, en, auto_reload   controller -> timer
//   q, busy, tc                       timer -> controller
// Modports: master (controller), slave (timer)
interface down_timer_if
    import down_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_W
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;

    modport master (
        output load, load_val, en, auto_reload,
        input  q, busy, tc
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output q, busy, tc
    );

endinterface

// File: rtl/down_timer_hs_cell.sv
// hs_cell: one-bit half-subtractor cell of the decrement borrow chain
// Ports:
//   b_in   borrow in from the lower bit
//   q      current counter bit
//   b_out  borrow out to the next bit
//   d      decremented bit
module hs_cell (
    input  logic b_in,
    input  logic q,
    output logic b_out,
    output logic d
);

    assign d     = q ^ b_in;
    assign b_out = ~q & b_in;

endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-cycle expiry pulse and optional auto-reload
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    down_timer_if.slave (load, load_val, en, auto_reload -> q, busy, tc)
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input logic         clk,
    input logic         rst_n,
    down_timer_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rl_q, rl_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] dec;
    logic [WIDTH:0]   b;
    logic             busy;
    logic             dec_en;
    logic             expire;
    logic             unused_borrow;

    assign busy   = |q_q;
    assign dec_en = bus.en & busy & ~bus.load;
    assign expire = dec_en & (q_q == WIDTH'(1));

    // With borrow-in low the chain passes q through unchanged, so it doubles as the hold path.
    assign b[0] = dec_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        hs_cell u_cell (
            .b_in (b[i]),
            .q    (q_q[i]),
            .b_out(b[i+1]),
            .d    (dec[i])
        );
    end

    // The chain only runs while q != 0, so the MSB borrow never asserts.
    assign unused_borrow = b[WIDTH];

    always_comb begin
        q_d  = bus.load ? bus.load_val : (expire & bus.auto_reload) ? rl_q : dec;
        rl_d = bus.load ? bus.load_val : rl_q;
        tc_d = expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q  <= '0;
            rl_q <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            rl_q <= rl_d;
            tc_q <= tc_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy;
    assign bus.tc   = tc_q;

endmodule
